// File: rtl/ws2812_mem_reader_if.sv
// ---------------------------------------------------------------------------
// ws2812_mem_reader_if
//   Bundles the frame-request handshake, the 8051 data-RAM read port and the
//   WS2812 line output of ws2812_mem_reader.
//   master : the reader (drives RAM address/strobe, LED line, busy/done)
//   slave  : the environment (drives start, returns RAM data)
// Signals
//   start     frame request, sampled only while the reader is idle
//   mem_addr  RAM read address (8 bit)
//   mem_rd_n  RAM read strobe, active-low, one cycle per byte
//   mem_data  RAM read data, combinational from mem_addr
//   led_dout  WS2812 one-wire NRZ data
//   busy      high while a frame is being fetched, sent or latched
//   done      one-cycle pulse when the latch time has elapsed
// ---------------------------------------------------------------------------
interface ws2812_mem_reader_if;
  logic       start;
  logic [7:0] mem_addr;
  logic       mem_rd_n;
  logic [7:0] mem_data;
  logic       led_dout;
  logic       busy;
  logic       done;

  modport master (
    input  start, mem_data,
    output mem_addr, mem_rd_n, led_dout, busy, done
  );

  modport slave (
    output start, mem_data,
    input  mem_addr, mem_rd_n, led_dout, busy, done
  );
endinterface

// File: rtl/ws2812_mem_reader.sv
// ---------------------------------------------------------------------------
// ws2812_mem_reader
//   Fetches the G,R,B colour table written by the 8051 into its data RAM and
//   serialises it MSB first onto a WS2812 chain, followed by the low latch
//   period. Every bit is exactly TBIT cycles; bytes follow each other with no
//   gap because the next byte is prefetched during the last bit of the
//   current one.
// Ports
//   clk  system clock, posedge
//   rst  synchronous reset, active-high
//   bus  ws2812_mem_reader_if.master : start, mem_addr, mem_rd_n, mem_data,
//        led_dout, busy, done (all outputs registered)
// ---------------------------------------------------------------------------
module ws2812_mem_reader #(
  parameter logic [7:0] BASE_ADDR = 8'h10,
  parameter int         NUM_LEDS  = 8,
  parameter int         T0H       = 20,
  parameter int         T1H       = 40,
  parameter int         TBIT      = 62,
  parameter int         TRESET    = 2600
) (
  input  logic                       clk,
  input  logic                       rst,
  ws2812_mem_reader_if.master        bus
);

  localparam int NBYTES = 3 * NUM_LEDS;
  localparam int TMAX   = (TBIT > TRESET) ? TBIT : TRESET;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int BW     = $clog2(NBYTES + 1);

  // Timer terminal counts: each phase runs from 0 up to its length minus one.
  localparam logic [TW-1:0] T0H_M1  = TW'(T0H - 1);
  localparam logic [TW-1:0] T1H_M1  = TW'(T1H - 1);
  localparam logic [TW-1:0] T0L_M1  = TW'(TBIT - T0H - 1);
  localparam logic [TW-1:0] T1L_M1  = TW'(TBIT - T1H - 1);
  localparam logic [TW-1:0] TRST_M1 = TW'(TRESET - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, BIT_HI, BIT_LO, LATCH} state_t;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    bit_q;
  logic [BW-1:0] byte_q;
  logic [7:0]    shift_q;
  logic [7:0]    hold_q;
  logic [7:0]    addr_q;
  logic          rd_n_q;
  logic          dout_q;
  logic          busy_q;
  logic          done_q;

  logic [TW-1:0] hi_end;
  logic [TW-1:0] lo_end;
  logic          last_byte;
  logic [7:0]    next_byte_d;

  assign hi_end    = shift_q[7] ? T1H_M1 : T0H_M1;
  assign lo_end    = shift_q[7] ? T1L_M1 : T0L_M1;
  assign last_byte = (byte_q == LAST_BYTE);
  // If the low phase is a single cycle, the prefetch strobe and the byte
  // boundary fall in the same cycle, so take the RAM data directly.
  assign next_byte_d = rd_n_q ? hold_q : bus.mem_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      addr_q  <= BASE_ADDR;
      rd_n_q  <= 1'b1;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rd_n_q <= 1'b1;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= FETCH;
            addr_q  <= BASE_ADDR;
            rd_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            byte_q  <= '0;
            timer_q <= '0;
          end
        end
        FETCH: begin
          shift_q <= bus.mem_data;
          bit_q   <= 3'd7;
          timer_q <= '0;
          dout_q  <= 1'b1;
          state_q <= BIT_HI;
        end
        BIT_HI: begin
          if (timer_q == hi_end) begin
            timer_q <= '0;
            dout_q  <= 1'b0;
            state_q <= BIT_LO;
            // Last bit of a non-final byte: strobe the next address in the
            // first low cycle so the byte is ready at the bit boundary.
            if ((bit_q == 3'd0) && !last_byte) begin
              rd_n_q <= 1'b0;
              addr_q <= addr_q + 8'd1;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        BIT_LO: begin
          if (!rd_n_q) hold_q <= bus.mem_data;
          if (timer_q == lo_end) begin
            timer_q <= '0;
            if (bit_q != 3'd0) begin
              shift_q <= {shift_q[6:0], 1'b0};
              bit_q   <= bit_q - 3'd1;
              dout_q  <= 1'b1;
              state_q <= BIT_HI;
            end else if (last_byte) begin
              state_q <= LATCH;
            end else begin
              shift_q <= next_byte_d;
              bit_q   <= 3'd7;
              byte_q  <= byte_q + BW'(1);
              dout_q  <= 1'b1;
              state_q <= BIT_HI;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        LATCH: begin
          if (timer_q == TRST_M1) begin
            timer_q <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr = addr_q;
  assign bus.mem_rd_n = rd_n_q;
  assign bus.led_dout = dout_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_ws2812_mem_reader.sv
// ---------------------------------------------------------------------------
// tb_ws2812_mem_reader
//   Three reader instances (8 LEDs @10h, 1 LED @10h, 1 LED @FEh) share one
//   RAM model; only the selected one sees start. Each frame is compared with
//   a waveform model derived from the RAM contents: per-bit high time, bit
//   period, strobe addresses, latency and total frame length.
// ---------------------------------------------------------------------------
module tb_ws2812_mem_reader;
  localparam int T0H = 20, T1H = 40, TBIT = 62, TRESET = 2600;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  int   sel = 0;
  logic [7:0] ram [256];

  int tests = 0;
  int fails = 0;

  ws2812_mem_reader_if ifa ();
  ws2812_mem_reader_if ifb ();
  ws2812_mem_reader_if ifc ();

  ws2812_mem_reader u_a (.clk(clk), .rst(rst), .bus(ifa));
  ws2812_mem_reader #(.NUM_LEDS(1)) u_b (.clk(clk), .rst(rst), .bus(ifb));
  ws2812_mem_reader #(.BASE_ADDR(8'hFE), .NUM_LEDS(1)) u_c (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  assign ifa.start    = start && (sel == 0);
  assign ifb.start    = start && (sel == 1);
  assign ifc.start    = start && (sel == 2);
  assign ifa.mem_data = ram[ifa.mem_addr];
  assign ifb.mem_data = ram[ifb.mem_addr];
  assign ifc.mem_data = ram[ifc.mem_addr];

  logic       led, busy, done, rd_n;
  logic [7:0] addr;
  always_comb begin
    led = ifa.led_dout; busy = ifa.busy; done = ifa.done; rd_n = ifa.mem_rd_n; addr = ifa.mem_addr;
    case (sel)
      1: begin led = ifb.led_dout; busy = ifb.busy; done = ifb.done; rd_n = ifb.mem_rd_n; addr = ifb.mem_addr; end
      2: begin led = ifc.led_dout; busy = ifc.busy; done = ifc.done; rd_n = ifc.mem_rd_n; addr = ifc.mem_addr; end
      default: ;
    endcase
  end

  task automatic check(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  logic [7:0] got_addr [$];
  int         got_len;

  // Runs one frame on the selected instance and checks it against the model.
  // pre_started: start was already driven in the previous done cycle.
  // chain:       drive start in this frame's done cycle.
  // poke:        pulse start during FETCH, bits and latch (must be ignored).
  task automatic run_frame(input bit pre_started, input bit chain, input bit poke);
    int nleds, nbytes, nbits, bper, exp_len, cyc, first_strobe;
    logic [7:0] base, a;
    int exp_hi [$];
    int rise [$];
    int fall [$];
    bit prev, busy_bad, seen_done;
    nleds   = (sel == 0) ? 8 : 1;
    base    = (sel == 2) ? 8'hFE : 8'h10;
    nbytes  = 3 * nleds;
    nbits   = 8 * nbytes;
    bper    = nbits * TBIT;
    exp_len = 1 + bper + TRESET + 1;
    for (int b = 0; b < nbytes; b++) begin
      a = base + 8'(b);
      for (int k = 7; k >= 0; k--) exp_hi.push_back(ram[a][k] ? T1H : T0H);
    end
    got_addr.delete();
    prev = 1'b0; busy_bad = 1'b0; seen_done = 1'b0; cyc = 0; first_strobe = -1;
    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1;
    end
    while (!seen_done && cyc < exp_len + 50) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (poke && (cyc == 1 || cyc == 100 || cyc == bper + 100)) start = 1'b1;
      if (!rd_n) begin
        got_addr.push_back(addr);
        if (first_strobe < 0) first_strobe = cyc;
      end
      if (led && !prev) rise.push_back(cyc);
      if (!led && prev) fall.push_back(cyc);
      prev = led;
      if (done) begin
        seen_done = 1'b1;
        if (busy) busy_bad = 1'b1;
        if (chain) start = 1'b1;
      end else if (!busy) begin
        busy_bad = 1'b1;
      end
    end
    got_len = seen_done ? cyc : -1;
    check("frame_len", got_len, exp_len);
    check("busy_window_errors", int'(busy_bad), 0);
    check("strobe_count", got_addr.size(), nbytes);
    check("first_strobe_cycle", first_strobe, 1);
    for (int b = 0; b < nbytes && b < got_addr.size(); b++) begin
      a = base + 8'(b);
      check($sformatf("strobe_addr[%0d]", b), int'(got_addr[b]), int'(a));
    end
    check("bit_rises", rise.size(), nbits);
    check("bit_falls", fall.size(), nbits);
    if (rise.size() > 0) check("first_rise_cycle", rise[0], 2);
    for (int i = 0; i < rise.size() && i < fall.size() && i < nbits; i++) begin
      check($sformatf("high_width[%0d]", i), fall[i] - rise[i], exp_hi[i]);
      if (i + 1 < rise.size())
        check($sformatf("bit_period[%0d]", i), rise[i + 1] - rise[i], TBIT);
      else if (seen_done)
        check("last_bit_plus_latch", got_len - rise[i], TBIT + TRESET);
    end
  endtask

  typedef struct {
    int         sel;
    logic [7:0] d0, d1, d2;
    logic [7:0] a0, a1, a2;
    int         len;
  } vec_t;

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [3];
    logic [7:0] base, a;
    vt[0] = '{1, 8'hA5, 8'h00, 8'hFF, 8'h10, 8'h11, 8'h12, 4090};
    vt[1] = '{2, 8'h3C, 8'h81, 8'h7E, 8'hFE, 8'hFF, 8'h00, 4090};
    vt[2] = '{1, 8'h00, 8'hFF, 8'h5A, 8'h10, 8'h11, 8'h12, 4090};
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_led_dout", int'(led), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_mem_rd_n", int'(rd_n), 1);
    check("rst_mem_addr", int'(addr), 8'h10);
    check("rst_mem_addr_fe", int'(ifc.mem_addr), 8'hFE);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single-LED frames
    for (int i = 0; i < 3; i++) begin
      sel  = vt[i].sel;
      base = (sel == 2) ? 8'hFE : 8'h10;
      ram[base] = vt[i].d0;
      a = base + 8'd1; ram[a] = vt[i].d1;
      a = base + 8'd2; ram[a] = vt[i].d2;
      run_frame(1'b0, 1'b0, 1'b0);
      if (got_addr.size() == 3) begin
        check($sformatf("vec%0d_addr0", i), int'(got_addr[0]), int'(vt[i].a0));
        check($sformatf("vec%0d_addr1", i), int'(got_addr[1]), int'(vt[i].a1));
        check($sformatf("vec%0d_addr2", i), int'(got_addr[2]), int'(vt[i].a2));
      end else begin
        check($sformatf("vec%0d_addr_count", i), got_addr.size(), 3);
      end
      check($sformatf("vec%0d_len", i), got_len, vt[i].len);
      @(negedge clk);
      check($sformatf("vec%0d_done_one_cycle", i), int'(done), 0);
    end

    // Eight LEDs, ramp data
    sel = 0;
    for (int i = 0; i < 24; i++) begin
      a = 8'h10 + 8'(i);
      ram[a] = 8'(i * 11 + 3);
    end
    run_frame(1'b0, 1'b0, 1'b0);

    // Random data against the model
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom_range(0, 255));
    sel = 0;
    run_frame(1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 256; i++) ram[i] = 8'($urandom_range(0, 255));
      sel = 1;
      run_frame(1'b0, 1'b0, 1'b0);
    end

    // Start while busy ignored; start in done cycle accepted
    sel = 1;
    run_frame(1'b0, 1'b1, 1'b1);
    run_frame(1'b1, 1'b0, 1'b0);
    @(negedge clk);

    // Reset during bit 5 high of byte 2
    sel = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (18 * TBIT + 4) @(negedge clk);
    check("pre_rst_led_high", int'(led), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_led_dout", int'(led), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_mem_rd_n", int'(rd_n), 1);
    check("midrst_mem_addr", int'(addr), 8'h10);
    run_frame(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
